muldiv_unit: RTL and testbench

Iterative multiply/divide unit implementing the RISC-V M-extension operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) for a parametrised datapath width. The ALU control decoder selects this unit when an R-type instruction carries funct7 = 0000001 and passes funct3 through unchanged. The unit runs alongside the single-cycle ALU in the execute stage and stalls the pipeline through `busy` for the duration of an operation.

---
 rtl/muldiv_pkg.sv | 24 ++
 rtl/muldiv_unit.sv | 156 +++++++++++++++
 tb/tb_muldiv_unit.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RISC-V M-extension multiply/divide unit:
// funct3 operation codes, FSM state type and an operation-class helper.
package muldiv_pkg;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic logic is_div(input logic [2:0] funct3);
      return funct3[2];
   endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide share one
// 2*XLEN accumulator and iteration counter; divide-by-zero and overflow bypass CALC.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(XLEN);
   localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

   state_t            state_reg, state_next;
   logic [CW-1:0]     cnt_reg, cnt_next;
   logic [2*XLEN-1:0] acc_reg, acc_next;
   logic [XLEN-1:0]   opnd_reg, opnd_next;
   logic [2:0]        op_reg, op_next;
   logic              neg_reg, neg_next;
   logic [XLEN-1:0]   result_reg, result_next;

   // Operand conditioning at accept
   logic            signed_a, signed_b, a_neg, b_neg;
   logic [XLEN-1:0] a_mag, b_mag;
   logic            div_zero, div_ovf, fast, accept;
   logic [XLEN-1:0] fast_result;

   assign signed_a = (funct3 == F3_MULH) | (funct3 == F3_MULHSU) |
                     (funct3 == F3_DIV)  | (funct3 == F3_REM);
   assign signed_b = (funct3 == F3_MULH) | (funct3 == F3_DIV) | (funct3 == F3_REM);
   assign a_neg    = signed_a & op_a[XLEN-1];
   assign b_neg    = signed_b & op_b[XLEN-1];
   assign a_mag    = a_neg ? -op_a : op_a;
   assign b_mag    = b_neg ? -op_b : op_b;

   assign div_zero = (op_b == '0);
   assign div_ovf  = signed_b & (op_a == {1'b1, {(XLEN-1){1'b0}}}) & (op_b == '1);
   assign fast     = is_div(funct3) & (div_zero | div_ovf);
   // funct3[1] distinguishes REM/REMU from DIV/DIVU
   assign fast_result = div_zero ? (funct3[1] ? op_a : '1)
                                 : (funct3[1] ? '0 : op_a);
   assign accept   = start & ~flush & (state_reg != CALC);

   // One iteration of either datapath
   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_step;
   logic [2*XLEN:0]   div_shift;
   logic [XLEN:0]     div_diff;
   logic [2*XLEN-1:0] div_step;
   logic [2*XLEN-1:0] step, prod_signed;
   logic [XLEN-1:0]   quot, rem, final_result;

   assign mul_sum   = {1'b0, acc_reg[2*XLEN-1:XLEN]} +
                      (acc_reg[0] ? {1'b0, opnd_reg} : '0);
   assign mul_step  = {mul_sum, acc_reg[XLEN-1:1]};
   // Restoring divide: carry bit lives in div_shift[2*XLEN] above the remainder
   assign div_shift = {acc_reg, 1'b0};
   assign div_diff  = div_shift[2*XLEN:XLEN] - {1'b0, opnd_reg};
   assign div_step  = div_diff[XLEN] ? div_shift[2*XLEN-1:0]
                                     : {div_diff[XLEN-1:0], div_shift[XLEN-1:1], 1'b1};
   assign step        = is_div(op_reg) ? div_step : mul_step;
   assign prod_signed = neg_reg ? -step : step;
   assign quot        = step[XLEN-1:0];
   assign rem         = step[2*XLEN-1:XLEN];

   always_comb begin
      final_result = '0;
      case (op_reg)
         F3_MUL:                        final_result = prod_signed[XLEN-1:0];
         F3_MULH, F3_MULHSU, F3_MULHU:  final_result = prod_signed[2*XLEN-1:XLEN];
         F3_DIV, F3_DIVU:               final_result = neg_reg ? -quot : quot;
         default:                       final_result = neg_reg ? -rem : rem;
      endcase
   end

   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      acc_next    = acc_reg;
      opnd_next   = opnd_reg;
      op_next     = op_reg;
      neg_next    = neg_reg;
      result_next = result_reg;
      case (state_reg)
         CALC: begin
            if (flush) begin
               state_next = IDLE;
            end else begin
               acc_next = step;
               if (cnt_reg == CNT_LAST) begin
                  state_next  = DONE;
                  result_next = final_result;
               end else begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end
         end
         default: begin
            state_next = IDLE;
            if (accept) begin
               op_next  = funct3;
               cnt_next = '0;
               if (fast) begin
                  state_next  = DONE;
                  result_next = fast_result;
               end else begin
                  state_next = CALC;
                  // Remainder follows the dividend; everything else the sign product
                  neg_next   = (is_div(funct3) & funct3[1]) ? a_neg : (a_neg ^ b_neg);
                  if (is_div(funct3)) begin
                     acc_next  = {{XLEN{1'b0}}, a_mag};
                     opnd_next = b_mag;
                  end else begin
                     acc_next  = {{XLEN{1'b0}}, b_mag};
                     opnd_next = a_mag;
                  end
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         cnt_reg    <= '0;
         acc_reg    <= '0;
         opnd_reg   <= '0;
         op_reg     <= '0;
         neg_reg    <= 1'b0;
         result_reg <= '0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         acc_reg    <= acc_next;
         opnd_reg   <= opnd_next;
         op_reg     <= op_next;
         neg_reg    <= neg_next;
         result_reg <= result_next;
      end
   end

   assign busy   = (state_reg == CALC);
   assign done   = (state_reg == DONE) & ~flush;
   assign result = result_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: an arithmetic reference plus a cycle-budget timeline
// model checked every cycle, with literal expectations for each directed vector.
module tb_muldiv_unit;

   localparam int XLEN = 32;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        flush = 1'b0;
   logic [2:0]  funct3 = 3'd0;
   logic [31:0] op_a = 32'd0;
   logic [31:0] op_b = 32'd0;
   logic        busy, done;
   logic [31:0] result;

   int total = 0;
   int bad   = 0;

   muldiv_unit #(.XLEN(XLEN)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .funct3 (funct3),
      .op_a   (op_a),
      .op_b   (op_b),
      .flush  (flush),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Arithmetic reference straight from the M-extension definitions
   function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
      logic [63:0] p;
      longint      sa, sb, ub;
      logic [31:0] r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ub = longint'({32'd0, b});
      r  = 32'd0;
      case (f)
         3'd0: begin p = sa * sb;                 r = p[31:0];  end
         3'd1: begin p = sa * sb;                 r = p[63:32]; end
         3'd2: begin p = sa * ub;                 r = p[63:32]; end
         3'd3: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
         3'd4: begin
            if (b == 32'd0) r = 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
            else begin p = sa / sb; r = p[31:0]; end
         end
         3'd5: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 32'd0) r = a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
            else begin p = sa % sb; r = p[31:0]; end
         end
         default: r = (b == 32'd0) ? a : a % b;
      endcase
      return r;
   endfunction

   function automatic bit is_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      return f[2] && (b == 32'd0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
   endfunction

   // Timeline model: cycles of busy remaining, whether this cycle is a done cycle
   int          m_left = 0;
   bit          m_done = 1'b0;
   logic [31:0] m_res  = 32'd0;
   logic [31:0] m_pend = 32'd0;

   always @(negedge rst_n) begin
      m_left = 0;
      m_done = 1'b0;
      m_res  = 32'd0;
   end

   always @(posedge clk) begin
      bit busy_now, done_nx;
      if (rst_n) begin
         busy_now = (m_left > 0);
         done_nx  = 1'b0;
         if (flush) begin
            m_left = 0;
         end else if (start && !busy_now) begin
            if (is_fast(funct3, op_a, op_b)) begin
               done_nx = 1'b1;
               m_res   = ref_result(funct3, op_a, op_b);
            end else begin
               m_left = XLEN;
               m_pend = ref_result(funct3, op_a, op_b);
            end
         end else if (busy_now) begin
            m_left--;
            if (m_left == 0) begin
               done_nx = 1'b1;
               m_res   = m_pend;
            end
         end
         m_done = done_nx;
      end
   end

   always @(negedge clk) begin
      chk("cyc_busy", busy, m_left > 0);
      chk("cyc_done", done, m_done && !flush);
      chk("cyc_result", result, m_res);
   end

   task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      start  = 1'b1;
      funct3 = f;
      op_a   = a;
      op_b   = b;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int first, output int lat);
      lat = first;
      forever begin
         @(negedge clk);
         if (done) break;
         lat++;
         if (lat > 100) begin
            chk("done_timeout", 64'd0, 64'd1);
            break;
         end
      end
   endtask

   task automatic run(input string name, input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
      int lat;
      issue(f, a, b);
      wait_done(1, lat);
      chk({name, "_lat"}, lat, exp_lat);
      chk(name, result, exp);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, seen;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_result", result, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      run("mul",    3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
      run("mulh",   3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33);
      run("mulhu",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
      run("mulhsu", 3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 33);
      run("div",    3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33);
      run("rem",    3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33);
      run("divu",   3'd5, 32'd100,        32'd7,         32'd14,        33);
      run("remu",   3'd7, 32'd100,        32'd7,         32'd2,         33);
      run("divu0",  3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1);
      run("rem0",   3'd6, 32'd5,          32'd0,         32'd5,         1);
      run("divovf", 3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
      run("divu7",  3'd5, 32'd100,        32'd7,         32'd14,        33);
      run("removf", 3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1);

      // flush at CALC cycle 10
      issue(3'd5, 32'd100, 32'd7);
      repeat (9) begin
         @(posedge clk);
         #1;
      end
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      chk("flush_busy", busy, 0);
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) seen++;
      end
      chk("flush_nodone", seen, 0);
      chk("flush_hold", result, 32'd0);
      @(posedge clk);
      #1;

      // flush in IDLE drops a same-cycle start
      start = 1'b1; flush = 1'b1; funct3 = 3'd0; op_a = 32'd3; op_b = 32'd3;
      @(posedge clk);
      #1;
      start = 1'b0; flush = 1'b0;
      @(negedge clk);
      chk("idleflush_busy", busy, 0);
      chk("idleflush_done", done, 0);
      @(posedge clk);
      #1;

      // start during CALC is ignored
      issue(3'd0, 32'd3, 32'd5);
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      start = 1'b1; funct3 = 3'd5; op_a = 32'd9; op_b = 32'd3;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(6, lat);
      chk("ignore_lat", lat, 33);
      chk("ignore_res", result, 32'd15);
      @(posedge clk);
      #1;

      // asynchronous reset mid-CALC
      issue(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      repeat (7) begin
         @(posedge clk);
         #1;
      end
      rst_n = 1'b0;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      chk("arst_result", result, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      run("mul34", 3'd0, 32'd3, 32'd4, 32'd12, 33);

      // back-to-back: start accepted in DONE
      issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done(1, lat);
      chk("b2b1_lat", lat, 33);
      chk("b2b1_res", result, 32'hFFFF_FFFE);
      start = 1'b1; funct3 = 3'd5; op_a = 32'd100; op_b = 32'd7;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(1, lat);
      chk("b2b2_lat", lat, 33);
      chk("b2b2_res", result, 32'd14);

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
